// File: rtl/mmem_rd_arbiter.sv
// Round-robin arbiter with burst lock for the shared main-memory read port.
// Registers the winning command and returns an owner tag aligned with read data.
module mmem_rd_arbiter #(
  parameter int N_REQ    = 3,
  parameter int ADDR_WDT = 14,
  parameter int TYPE_WDT = 3,
  parameter int RD_LAT   = 2,
  parameter int ID_WDT   = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [N_REQ-1:0]             req_val,
  input  logic [N_REQ*ADDR_WDT-1:0]    req_addr,
  input  logic [N_REQ*TYPE_WDT-1:0]    req_type,
  input  logic [N_REQ-1:0]             req_last,
  input  logic [N_REQ-1:0]             req_stall,
  output logic [N_REQ-1:0]             req_rdy,
  output logic                         mem_rd_en,
  output logic [ADDR_WDT-1:0]          mem_rd_addr,
  output logic [TYPE_WDT-1:0]          mem_rd_type,
  output logic                         mem_rd_last,
  output logic                         rsp_val,
  output logic [ID_WDT-1:0]            rsp_id,
  output logic                         busy
);

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } state_t;

  localparam logic [ID_WDT-1:0] PTR_RST = ID_WDT'(N_REQ - 1);

  state_t                state_q, state_d;
  logic [ID_WDT-1:0]     ptr_q, ptr_d;
  logic [ID_WDT-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]      elig;
  logic                  grant_vld;
  logic [ID_WDT-1:0]     grant_id;
  logic [ID_WDT-1:0]     cand;

  logic [ADDR_WDT-1:0]   addr_arr [N_REQ];
  logic [TYPE_WDT-1:0]   type_arr [N_REQ];

  logic                  mem_rd_en_q;
  logic [ADDR_WDT-1:0]   mem_rd_addr_q;
  logic [TYPE_WDT-1:0]   mem_rd_type_q;
  logic                  mem_rd_last_q;
  logic [ID_WDT-1:0]     cmd_id_q;

  logic [RD_LAT-1:0]     tag_vld_q;
  logic [ID_WDT-1:0]     tag_id_q [RD_LAT];

  for (genvar g = 0; g < N_REQ; g++) begin : g_split
    assign addr_arr[g] = req_addr[g*ADDR_WDT +: ADDR_WDT];
    assign type_arr[g] = req_type[g*TYPE_WDT +: TYPE_WDT];
  end

  // Gating with rst_n keeps req_rdy low while reset is held, like every other output.
  assign elig = req_val & ~req_stall & {N_REQ{~clear & rst_n}};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    req_rdy   = '0;

    if (state_q == ST_IDLE) begin
      for (int k = N_REQ; k >= 1; k--) begin
        // Scanning from farthest to nearest leaves the nearest eligible index as winner.
        cand = ID_WDT'((int'(ptr_q) + k) % N_REQ);
        if (elig[cand]) begin
          grant_vld = 1'b1;
          grant_id  = cand;
        end
      end
    end else begin
      grant_vld = elig[owner_q];
      grant_id  = owner_q;
    end

    if (grant_vld) begin
      req_rdy[grant_id] = 1'b1;
      ptr_d             = grant_id;
      if (state_q == ST_IDLE && !req_last[grant_id]) begin
        state_d = ST_LOCK;
        owner_d = grant_id;
      end else if (state_q == ST_LOCK && req_last[grant_id]) begin
        state_d = ST_IDLE;
      end
    end

    if (clear) begin
      state_d = ST_IDLE;
      ptr_d   = PTR_RST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Command register: address/type/last hold their value when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_rd_type_q <= '0;
      mem_rd_last_q <= 1'b0;
      cmd_id_q      <= '0;
    end else begin
      mem_rd_en_q <= grant_vld;
      if (grant_vld) begin
        mem_rd_addr_q <= addr_arr[grant_id];
        mem_rd_type_q <= type_arr[grant_id];
        mem_rd_last_q <= req_last[grant_id];
        cmd_id_q      <= grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the id payload is reset along with the valid bits so rsp_id reads 0 out of reset.
      tag_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_id_q[i] <= '0;
    end else if (clear) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= mem_rd_en_q;
      tag_id_q[0]  <= cmd_id_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign mem_rd_type = mem_rd_type_q;
  assign mem_rd_last = mem_rd_last_q;
  assign rsp_val     = tag_vld_q[RD_LAT-1];
  assign rsp_id      = tag_id_q[RD_LAT-1];
  assign busy        = (state_q == ST_LOCK) | mem_rd_en_q | (|tag_vld_q);

endmodule

// File: tb/tb_mmem_rd_arbiter.sv
// Directed bench for mmem_rd_arbiter: reset, latency, round-robin, burst lock, stall, clear.
module tb_mmem_rd_arbiter;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int TW = 3;
  localparam int RL = 3;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic            clear;
  logic [N-1:0]    req_val;
  logic [N*AW-1:0] req_addr;
  logic [N*TW-1:0] req_type;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_stall;
  logic [N-1:0]    req_rdy;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [TW-1:0]   mem_rd_type;
  logic            mem_rd_last;
  logic            rsp_val;
  logic [IW-1:0]   rsp_id;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  mmem_rd_arbiter #(
    .N_REQ(N), .ADDR_WDT(AW), .TYPE_WDT(TW), .RD_LAT(RL), .ID_WDT(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_val(req_val), .req_addr(req_addr), .req_type(req_type),
    .req_last(req_last), .req_stall(req_stall), .req_rdy(req_rdy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_type(mem_rd_type),
    .mem_rd_last(mem_rd_last), .rsp_val(rsp_val), .rsp_id(rsp_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t,
                         input logic l);
    req_addr[i*AW +: AW] = a;
    req_type[i*TW +: TW] = t;
    req_last[i]          = l;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; req_val = '0; req_addr = '0;
    req_type = '0; req_last = '0; req_stall = '0;

    // Reset state
    step(); step(); #1;
    check("rst_rdy", 32'(req_rdy), 32'h0);
    check("rst_en", 32'(mem_rd_en), 32'h0);
    check("rst_rsp", 32'(rsp_val), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    step(); rst_n = 1'b1;

    // Latency: single beat from requester 1
    step();
    set_req(1, 14'h1A2, 3'd5, 1'b1); req_val = 3'b010; #1;
    check("lat_rdy", 32'(req_rdy), 32'h2);
    step(); req_val = '0; #1;
    check("lat_en", 32'(mem_rd_en), 32'h1);
    check("lat_addr", 32'(mem_rd_addr), 32'h1A2);
    check("lat_type", 32'(mem_rd_type), 32'h5);
    check("lat_last", 32'(mem_rd_last), 32'h1);
    check("lat_busy", 32'(busy), 32'h1);
    step(); #1;
    check("lat_en_off", 32'(mem_rd_en), 32'h0);
    check("lat_addr_hold", 32'(mem_rd_addr), 32'h1A2);
    step(); #1;
    check("lat_rsp_early", 32'(rsp_val), 32'h0);
    step(); #1;
    check("lat_rsp_val", 32'(rsp_val), 32'h1);
    check("lat_rsp_id", 32'(rsp_id), 32'h1);
    step(); #1;
    check("lat_rsp_done", 32'(rsp_val), 32'h0);
    check("lat_busy_done", 32'(busy), 32'h0);

    // Clear blocks rdy and returns the pointer so the next scan starts at 0
    for (int i = 0; i < N; i++) set_req(i, 14'(32'h100 + i), 3'(i), 1'b1);
    req_val = 3'b111; clear = 1'b1; #1;
    check("clr_rdy", 32'(req_rdy), 32'h0);
    step(); clear = 1'b0;

    // Round-robin fairness, single-beat grants every cycle
    for (int c = 0; c < 11; c++) begin
      if (c == 6) req_val = '0;
      #1;
      if (c < 6) check("rr_rdy", 32'(req_rdy), 32'(1 << (c % 3)));
      if (c >= 1 && c <= 6) begin
        check("rr_en", 32'(mem_rd_en), 32'h1);
        check("rr_addr", 32'(mem_rd_addr), 32'h100 + 32'((c - 1) % 3));
      end
      check("rr_rsp_val", 32'(rsp_val), 32'((c >= 4 && c <= 9) ? 1 : 0));
      if (c >= 4 && c <= 9) check("rr_rsp_id", 32'(rsp_id), 32'((c - 4) % 3));
      step();
    end

    // Burst lock: req0 four beats, req1 waiting throughout
    set_req(0, 14'h200, 3'd1, 1'b0); set_req(1, 14'h300, 3'd2, 1'b1);
    req_val = 3'b011; #1;
    check("lock_b1_rdy", 32'(req_rdy), 32'h1);
    step(); set_req(0, 14'h201, 3'd1, 1'b0); #1;
    check("lock_b2_rdy", 32'(req_rdy), 32'h1);
    check("lock_b1_addr", 32'(mem_rd_addr), 32'h200);
    check("lock_b1_last", 32'(mem_rd_last), 32'h0);
    step(); req_val = 3'b010; #1;
    check("lock_gap_rdy", 32'(req_rdy), 32'h0);
    check("lock_gap_busy", 32'(busy), 32'h1);
    step(); req_val = 3'b011; set_req(0, 14'h202, 3'd1, 1'b0); #1;
    check("lock_b3_rdy", 32'(req_rdy), 32'h1);
    step(); set_req(0, 14'h203, 3'd1, 1'b1); #1;
    check("lock_b4_rdy", 32'(req_rdy), 32'h1);
    check("lock_b3_addr", 32'(mem_rd_addr), 32'h202);
    step(); req_val = 3'b010; #1;
    check("lock_rel_rdy", 32'(req_rdy), 32'h2);
    check("lock_b4_addr", 32'(mem_rd_addr), 32'h203);
    check("lock_b4_last", 32'(mem_rd_last), 32'h1);
    step(); req_val = '0; #1;
    check("lock_r1_addr", 32'(mem_rd_addr), 32'h300);
    check("lock_r1_en", 32'(mem_rd_en), 32'h1);
    for (int i = 0; i < 6; i++) step();

    // Stall on requester 1 gates its grant until released
    set_req(2, 14'h222, 3'd3, 1'b1);
    req_stall = 3'b010; req_val = 3'b110; #1;
    check("stall_rdy_a", 32'(req_rdy), 32'h4);
    step(); #1;
    check("stall_rdy_b", 32'(req_rdy), 32'h4);
    step(); req_stall = '0; #1;
    check("stall_rel_rdy", 32'(req_rdy), 32'h2);
    step(); req_val = '0;
    for (int i = 0; i < 6; i++) step();

    // Clear in LOCK with three reads in flight
    set_req(0, 14'h050, 3'd0, 1'b0); req_val = 3'b001; #1;
    check("clrl_b1_rdy", 32'(req_rdy), 32'h1);
    step(); step(); #1;
    check("clrl_b3_rdy", 32'(req_rdy), 32'h1);
    step(); clear = 1'b1; #1;
    check("clrl_rdy", 32'(req_rdy), 32'h0);
    check("clrl_rsp", 32'(rsp_val), 32'h0);
    check("clrl_busy", 32'(busy), 32'h1);
    step(); clear = 1'b0; req_val = '0; #1;
    check("clrl_en_after", 32'(mem_rd_en), 32'h0);
    check("clrl_busy_after", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("clrl_rsp_flushed", 32'(rsp_val), 32'h0);
      step();
    end
    req_last = 3'b111; req_val = 3'b111; #1;
    check("clrl_next_rdy", 32'(req_rdy), 32'h1);
    step(); req_val = '0;

    // Asynchronous reset mid-burst with tags in flight
    set_req(1, 14'h0AA, 3'd4, 1'b0); req_val = 3'b010; #1;
    check("rstb_b1_rdy", 32'(req_rdy), 32'h2);
    step(); #1;
    check("rstb_b2_rdy", 32'(req_rdy), 32'h2);
    step(); #1;
    rst_n = 1'b0; #1;
    check("rstb_en", 32'(mem_rd_en), 32'h0);
    check("rstb_addr", 32'(mem_rd_addr), 32'h0);
    check("rstb_type", 32'(mem_rd_type), 32'h0);
    check("rstb_rdy", 32'(req_rdy), 32'h0);
    check("rstb_busy", 32'(busy), 32'h0);
    check("rstb_rsp", 32'(rsp_val), 32'h0);
    req_val = '0;
    step(); step(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rstb_rsp_after", 32'(rsp_val), 32'h0);
      check("rstb_busy_after", 32'(busy), 32'h0);
      step();
    end
    set_req(1, 14'h0AB, 3'd4, 1'b1); req_val = 3'b010; #1;
    check("rstb_next_rdy", 32'(req_rdy), 32'h2);
    step(); req_val = '0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
